// File: rtl/if_fetch_unit_pkg.sv
// Shared fetch-stage constants: datapath widths, boot PC and buffer sizing.
package if_fetch_unit_pkg;

   localparam int          FU_XLEN     = 64;
   localparam int          FU_INST_W   = 32;
   localparam logic [63:0] FU_PC_START = 64'h8000_0000;
   localparam int          FU_PC_STEP  = 4;
   localparam int          FU_DEPTH    = 4;

   // Counter width able to hold 0..depth inclusive.
   function automatic int cnt_width(input int depth);
      return $clog2(depth) + 1;
   endfunction

endpackage

// File: rtl/if_fetch_unit_fetch_fifo.sv
// Synchronous FIFO with registered storage, flush and occupancy count.
module fetch_fifo
   import if_fetch_unit_pkg::*;
#(
   parameter int WIDTH = 8,
   parameter int DEPTH = 4
)(
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     i_push,
   input  logic [WIDTH-1:0]         i_push_data,
   input  logic                     i_pop,
   input  logic                     i_flush,
   output logic [WIDTH-1:0]         o_head,
   output logic [$clog2(DEPTH):0]   o_count,
   output logic                     o_full,
   output logic                     o_empty
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = cnt_width(DEPTH);

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [AW-1:0]    r_wr_ptr;
   logic [AW-1:0]    r_rd_ptr;
   logic [CW-1:0]    r_count;
   logic             w_do_push;
   logic             w_do_pop;

   assign o_empty   = (r_count == '0);
   assign o_full    = (r_count == CW'(DEPTH));
   assign o_count   = r_count;
   assign o_head    = r_mem[r_rd_ptr];
   assign w_do_pop  = i_pop && !o_empty;
   // A push into a full FIFO is legal when the head leaves in the same cycle.
   assign w_do_push = i_push && (!o_full || w_do_pop);

   always_ff @(posedge clk) begin
      if (rst || i_flush) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_do_push) r_wr_ptr <= r_wr_ptr + AW'(1);
         if (w_do_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
         r_count <= r_count + CW'(w_do_push) - CW'(w_do_pop);
      end
   end

   always_ff @(posedge clk) begin
      if (w_do_push) r_mem[r_wr_ptr] <= i_push_data;
   end

endmodule

// File: rtl/if_fetch_unit.sv
// Instruction fetch stage: credit-limited sequential PC requests, in-order
// response pairing through a pc-tag queue, and a decode-side instruction buffer.
module if_fetch_unit
   import if_fetch_unit_pkg::*;
#(
   parameter int              XLEN     = FU_XLEN,
   parameter int              INST_W   = FU_INST_W,
   parameter logic [XLEN-1:0] PC_START = XLEN'(FU_PC_START),
   parameter int              PC_STEP  = FU_PC_STEP,
   parameter int              DEPTH    = FU_DEPTH
)(
   input  logic              clk,
   input  logic              rst,
   input  logic              redirect_valid,
   input  logic [XLEN-1:0]   redirect_pc,
   output logic              imem_req_valid,
   input  logic              imem_req_ready,
   output logic [XLEN-1:0]   imem_req_addr,
   input  logic              imem_resp_valid,
   input  logic [INST_W-1:0] imem_resp_data,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [XLEN-1:0]   out_pc,
   output logic [INST_W-1:0] out_inst
);

   localparam int CNT_W = cnt_width(DEPTH);
   localparam int OCC_W = CNT_W + 1;

   logic                   r_rst_q;
   logic [XLEN-1:0]        r_pc;
   logic [CNT_W-1:0]       r_inflight;
   logic [CNT_W-1:0]       r_drop;

   logic [XLEN+INST_W-1:0] w_ibuf_head;
   logic [CNT_W-1:0]       w_ibuf_count;
   logic                   w_ibuf_full;
   logic                   w_ibuf_empty;
   logic [XLEN-1:0]        w_tag_head;
   logic [CNT_W-1:0]       w_tag_count;
   logic                   w_tag_full;
   logic                   w_tag_empty;

   logic [OCC_W-1:0]       w_occ;
   logic                   w_req_valid;
   logic                   w_accept;
   logic                   w_keep_resp;
   logic                   w_pop;

   // Every accepted request reserves a buffer slot until it is consumed.
   assign w_occ       = OCC_W'(w_ibuf_count) + OCC_W'(r_inflight);
   assign w_req_valid = !rst && !r_rst_q && !redirect_valid && (w_occ < OCC_W'(DEPTH));
   assign w_accept    = w_req_valid && imem_req_ready;
   assign w_keep_resp = imem_resp_valid && (r_drop == '0) && !redirect_valid;
   assign w_pop       = out_valid && out_ready;

   assign imem_req_valid = w_req_valid;
   assign imem_req_addr  = r_pc;
   assign out_valid      = !rst && !w_ibuf_empty;
   assign out_pc         = w_ibuf_head[XLEN+INST_W-1:INST_W];
   assign out_inst       = w_ibuf_head[INST_W-1:0];

   fetch_fifo #(.WIDTH(XLEN+INST_W), .DEPTH(DEPTH)) u_ibuf (
      .clk         (clk),
      .rst         (rst),
      .i_push      (w_keep_resp),
      .i_push_data ({w_tag_head, imem_resp_data}),
      .i_pop       (w_pop),
      .i_flush     (redirect_valid),
      .o_head      (w_ibuf_head),
      .o_count     (w_ibuf_count),
      .o_full      (w_ibuf_full),
      .o_empty     (w_ibuf_empty)
   );

   fetch_fifo #(.WIDTH(XLEN), .DEPTH(DEPTH)) u_tagq (
      .clk         (clk),
      .rst         (rst),
      .i_push      (w_accept),
      .i_push_data (r_pc),
      .i_pop       (w_keep_resp),
      .i_flush     (redirect_valid),
      .o_head      (w_tag_head),
      .o_count     (w_tag_count),
      .o_full      (w_tag_full),
      .o_empty     (w_tag_empty)
   );

   // Holds requests off for one extra cycle after reset is released.
   always_ff @(posedge clk) begin
      r_rst_q <= rst;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_pc       <= PC_START;
         r_inflight <= '0;
         r_drop     <= '0;
      end else begin
         r_inflight <= r_inflight + CNT_W'(w_accept) - CNT_W'(imem_resp_valid);
         if (redirect_valid) begin
            r_pc   <= redirect_pc & ~XLEN'(3);
            // Everything still outstanding after this cycle belongs to the old path.
            r_drop <= r_inflight - CNT_W'(imem_resp_valid);
         end else begin
            if (w_accept) r_pc <= r_pc + XLEN'(PC_STEP);
            if (imem_resp_valid && (r_drop != '0)) r_drop <= r_drop - CNT_W'(1);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         assert (!(imem_resp_valid && (r_inflight == '0)));
         assert (!(w_keep_resp && w_tag_empty));
         assert (!(w_keep_resp && w_ibuf_full && !w_pop));
         assert (!(w_accept && w_tag_full));
         assert (w_tag_count <= r_inflight);
      end
   end

endmodule

// File: tb/tb_if_fetch_unit.sv
// Bench for if_fetch_unit: memory model with per-request latency and a
// request-level reference model that tracks stale fetches per request.
module tb_if_fetch_unit;

   localparam logic [63:0] PC_START = 64'h8000_0000;
   localparam int          DEPTH    = 4;

   logic        clk;
   logic        rst;
   logic        redirect_valid;
   logic [63:0] redirect_pc;
   logic        imem_req_valid;
   logic        imem_req_ready;
   logic [63:0] imem_req_addr;
   logic        imem_resp_valid;
   logic [31:0] imem_resp_data;
   logic        out_valid;
   logic        out_ready;
   logic [63:0] out_pc;
   logic [31:0] out_inst;

   if_fetch_unit u_dut (
      .clk             (clk),
      .rst             (rst),
      .redirect_valid  (redirect_valid),
      .redirect_pc     (redirect_pc),
      .imem_req_valid  (imem_req_valid),
      .imem_req_ready  (imem_req_ready),
      .imem_req_addr   (imem_req_addr),
      .imem_resp_valid (imem_resp_valid),
      .imem_resp_data  (imem_resp_data),
      .out_valid       (out_valid),
      .out_ready       (out_ready),
      .out_pc          (out_pc),
      .out_inst        (out_inst)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   typedef struct {
      logic [63:0] addr;
      int          due;
      bit          stale;
   } req_t;

   typedef struct {
      logic [63:0] pc;
      logic [31:0] inst;
   } ent_t;

   req_t        mq[$];
   ent_t        ifq[$];
   logic [63:0] m_pc;
   bit          m_rst_prev;
   int          cyc;
   int          lat;
   int          resp_pct;
   int          n_checks;
   int          n_pass;
   logic [64:0] s_req, e_req;
   logic [96:0] s_out, e_out;

   function automatic logic [31:0] inst_of(input logic [63:0] a);
      return a[33:2] ^ a[63:32] ^ 32'hC0DE_1234;
   endfunction

   // One clock cycle: memory drives its response, outputs are sampled well
   // before the rising edge, expectations are formed, then the model advances.
   task automatic step();
      req_t r;
      bit   e_req_valid;
      bit   e_out_valid;
      if (!rst && mq.size() > 0 && mq[0].due <= cyc && $urandom_range(99) < resp_pct) begin
         imem_resp_valid = 1'b1;
         imem_resp_data  = inst_of(mq[0].addr);
      end else begin
         imem_resp_valid = 1'b0;
         imem_resp_data  = $urandom;
      end
      #1;
      e_req_valid = !rst && !m_rst_prev && !redirect_valid && (ifq.size() + mq.size() < DEPTH);
      e_out_valid = !rst && (ifq.size() > 0);
      e_req = {e_req_valid, rst ? 64'h0 : m_pc};
      s_req = {imem_req_valid, rst ? 64'h0 : imem_req_addr};
      e_out = e_out_valid ? {1'b1, ifq[0].pc, ifq[0].inst} : 97'h0;
      s_out = out_valid ? {1'b1, out_pc, out_inst} : 97'h0;

      if (rst) begin
         mq.delete();
         ifq.delete();
         m_pc       = PC_START;
         m_rst_prev = 1'b1;
      end else begin
         if (e_out_valid && out_ready) ifq.delete(0);
         if (imem_resp_valid) begin
            r = mq.pop_front();
            if (!r.stale && !redirect_valid) ifq.push_back('{r.addr, inst_of(r.addr)});
         end
         if (redirect_valid) begin
            ifq.delete();
            foreach (mq[i]) mq[i].stale = 1'b1;
            m_pc = redirect_pc & ~64'h3;
         end
         if (e_req_valid && imem_req_ready) begin
            mq.push_back('{m_pc, cyc + lat, 1'b0});
            m_pc = m_pc + 64'd4;
         end
         m_rst_prev = 1'b0;
      end
      @(negedge clk);
      cyc++;
   endtask

   task automatic do_reset();
      rst            = 1'b1;
      redirect_valid = 1'b0;
      imem_req_ready = 1'b0;
      out_ready      = 1'b0;
      resp_pct       = 100;
      step();
      rst = 1'b0;
      step();
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (2) begin
         step();
         n_checks += 2;
         if (s_req[64] !== 1'b0) $display("FAIL reset_req_valid got=%b exp=0", s_req[64]);
         else n_pass++;
         if (s_out[96] !== 1'b0) $display("FAIL reset_out_valid got=%b exp=0", s_out[96]);
         else n_pass++;
      end
      rst = 1'b0;
      step();
      n_checks += 2;
      if (s_req !== {1'b0, PC_START}) $display("FAIL post_reset_req got=%h exp=%h", s_req, {1'b0, PC_START});
      else n_pass++;
      if (s_out !== 97'h0) $display("FAIL post_reset_out got=%h exp=0", s_out);
      else n_pass++;
   endtask

   task automatic test_sequential();
      logic [64:0] exp_req;
      imem_req_ready = 1'b1;
      out_ready      = 1'b1;
      lat            = 1;
      resp_pct       = 100;
      for (int i = 0; i < 14; i++) begin
         step();
         if (i < 3) begin
            exp_req = {1'b1, PC_START + 64'(4 * i)};
            n_checks++;
            if (s_req !== exp_req) $display("FAIL seq_first_reqs i=%0d got=%h exp=%h", i, s_req, exp_req);
            else n_pass++;
         end
         n_checks += 2;
         if (s_req !== e_req) $display("FAIL seq_req cyc=%0d got=%h exp=%h", cyc, s_req, e_req);
         else n_pass++;
         if (s_out !== e_out) $display("FAIL seq_out cyc=%0d got=%h exp=%h", cyc, s_out, e_out);
         else n_pass++;
      end
   endtask

   task automatic test_backpressure();
      int n_acc;
      do_reset();
      imem_req_ready = 1'b1;
      out_ready      = 1'b0;
      lat            = 1;
      n_acc          = 0;
      for (int i = 0; i < 10; i++) begin
         step();
         if (s_req[64]) n_acc++;
         n_checks += 2;
         if (s_req !== e_req) $display("FAIL bp_req cyc=%0d got=%h exp=%h", cyc, s_req, e_req);
         else n_pass++;
         if (s_out !== e_out) $display("FAIL bp_out cyc=%0d got=%h exp=%h", cyc, s_out, e_out);
         else n_pass++;
      end
      n_checks += 2;
      if (n_acc !== DEPTH) $display("FAIL bp_accept_count got=%0d exp=%0d", n_acc, DEPTH);
      else n_pass++;
      if (s_req[64] !== 1'b0) $display("FAIL bp_req_stalled got=%b exp=0", s_req[64]);
      else n_pass++;
      out_ready = 1'b1;
      for (int i = 0; i < 10; i++) begin
         step();
         n_checks += 2;
         if (s_req !== e_req) $display("FAIL bp_drain_req cyc=%0d got=%h exp=%h", cyc, s_req, e_req);
         else n_pass++;
         if (s_out !== e_out) $display("FAIL bp_drain_out cyc=%0d got=%h exp=%h", cyc, s_out, e_out);
         else n_pass++;
      end
   endtask

   task automatic test_redirect();
      bit seen_req, seen_out;
      do_reset();
      imem_req_ready = 1'b1;
      out_ready      = 1'b1;
      lat            = 3;
      repeat (3) step();
      imem_req_ready = 1'b0;
      redirect_valid = 1'b1;
      redirect_pc    = 64'h8000_1002;
      step();
      redirect_valid = 1'b0;
      n_checks++;
      if (s_req[64] !== 1'b0) $display("FAIL redir_cycle_req got=%b exp=0", s_req[64]);
      else n_pass++;
      imem_req_ready = 1'b1;
      seen_req = 0;
      seen_out = 0;
      for (int i = 0; i < 15; i++) begin
         step();
         if (!seen_req && s_req[64]) begin
            seen_req = 1;
            n_checks++;
            if (s_req[63:0] !== 64'h8000_1000) $display("FAIL redir_first_addr got=%h exp=%h", s_req[63:0], 64'h8000_1000);
            else n_pass++;
         end
         if (!seen_out && s_out[96]) begin
            seen_out = 1;
            n_checks++;
            if (s_out[95:32] !== 64'h8000_1000) $display("FAIL redir_first_out_pc got=%h exp=%h", s_out[95:32], 64'h8000_1000);
            else n_pass++;
         end
         n_checks += 2;
         if (s_req !== e_req) $display("FAIL redir_req cyc=%0d got=%h exp=%h", cyc, s_req, e_req);
         else n_pass++;
         if (s_out !== e_out) $display("FAIL redir_out cyc=%0d got=%h exp=%h", cyc, s_out, e_out);
         else n_pass++;
      end
      n_checks++;
      if (!(seen_req && seen_out)) $display("FAIL redir_timeout seen_req=%0d seen_out=%0d exp=1/1", seen_req, seen_out);
      else n_pass++;
   endtask

   task automatic test_redirect_resp();
      bit seen_out;
      do_reset();
      imem_req_ready = 1'b1;
      out_ready      = 1'b1;
      lat            = 1;
      repeat (2) step();
      redirect_valid = 1'b1;
      redirect_pc    = 64'h4000_0100;
      step();
      redirect_valid = 1'b0;
      seen_out = 0;
      for (int i = 0; i < 10; i++) begin
         step();
         if (!seen_out && s_out[96]) begin
            seen_out = 1;
            n_checks++;
            if (s_out[95:32] !== 64'h4000_0100) $display("FAIL rr_first_out_pc got=%h exp=%h", s_out[95:32], 64'h4000_0100);
            else n_pass++;
         end
         n_checks += 2;
         if (s_req !== e_req) $display("FAIL rr_req cyc=%0d got=%h exp=%h", cyc, s_req, e_req);
         else n_pass++;
         if (s_out !== e_out) $display("FAIL rr_out cyc=%0d got=%h exp=%h", cyc, s_out, e_out);
         else n_pass++;
      end
      n_checks++;
      if (!seen_out) $display("FAIL rr_timeout seen_out=0 exp=1");
      else n_pass++;
      resp_pct = 80;
      for (int i = 0; i < 400; i++) begin
         imem_req_ready = ($urandom_range(3) != 0);
         out_ready      = ($urandom_range(9) < 7);
         lat            = $urandom_range(4, 1);
         redirect_valid = ($urandom_range(11) == 0);
         redirect_pc    = {$urandom, $urandom};
         step();
         n_checks += 2;
         if (s_req !== e_req) $display("FAIL rand_req cyc=%0d got=%h exp=%h", cyc, s_req, e_req);
         else n_pass++;
         if (s_out !== e_out) $display("FAIL rand_out cyc=%0d got=%h exp=%h", cyc, s_out, e_out);
         else n_pass++;
      end
      redirect_valid = 1'b0;
      resp_pct       = 100;
   endtask

   task automatic test_wrap();
      do_reset();
      redirect_valid = 1'b1;
      redirect_pc    = 64'hFFFF_FFFF_FFFF_FFFD;
      step();
      redirect_valid = 1'b0;
      imem_req_ready = 1'b1;
      out_ready      = 1'b1;
      lat            = 1;
      step();
      n_checks++;
      if (s_req !== {1'b1, 64'hFFFF_FFFF_FFFF_FFFC}) $display("FAIL wrap_top_req got=%h exp=%h", s_req, {1'b1, 64'hFFFF_FFFF_FFFF_FFFC});
      else n_pass++;
      step();
      n_checks++;
      if (s_req !== {1'b1, 64'h0}) $display("FAIL wrap_zero_req got=%h exp=%h", s_req, {1'b1, 64'h0});
      else n_pass++;
      for (int i = 0; i < 6; i++) begin
         step();
         n_checks += 2;
         if (s_req !== e_req) $display("FAIL wrap_req cyc=%0d got=%h exp=%h", cyc, s_req, e_req);
         else n_pass++;
         if (s_out !== e_out) $display("FAIL wrap_out cyc=%0d got=%h exp=%h", cyc, s_out, e_out);
         else n_pass++;
      end
   endtask

   task automatic test_reset_mid();
      do_reset();
      imem_req_ready = 1'b1;
      out_ready      = 1'b0;
      lat            = 2;
      repeat (3) step();
      imem_req_ready = 1'b0;
      step();
      n_checks++;
      if (s_out !== e_out) $display("FAIL rm_before_out got=%h exp=%h", s_out, e_out);
      else n_pass++;
      rst = 1'b1;
      step();
      n_checks++;
      if ({s_req[64], s_out[96]} !== 2'b00) $display("FAIL rm_rst_cycle got=%b exp=00", {s_req[64], s_out[96]});
      else n_pass++;
      rst = 1'b0;
      imem_req_ready = 1'b1;
      step();
      n_checks += 2;
      if (s_req !== {1'b0, PC_START}) $display("FAIL rm_after_req got=%h exp=%h", s_req, {1'b0, PC_START});
      else n_pass++;
      if (s_out !== 97'h0) $display("FAIL rm_after_out got=%h exp=0", s_out);
      else n_pass++;
      step();
      n_checks++;
      if (s_req !== {1'b1, PC_START}) $display("FAIL rm_restart_req got=%h exp=%h", s_req, {1'b1, PC_START});
      else n_pass++;
      out_ready = 1'b1;
      for (int i = 0; i < 8; i++) begin
         step();
         n_checks += 2;
         if (s_req !== e_req) $display("FAIL rm_req cyc=%0d got=%h exp=%h", cyc, s_req, e_req);
         else n_pass++;
         if (s_out !== e_out) $display("FAIL rm_out cyc=%0d got=%h exp=%h", cyc, s_out, e_out);
         else n_pass++;
      end
   endtask

   initial begin
      n_checks        = 0;
      n_pass          = 0;
      cyc             = 0;
      lat             = 1;
      resp_pct        = 100;
      m_pc            = PC_START;
      m_rst_prev      = 1'b1;
      rst             = 1'b1;
      redirect_valid  = 1'b0;
      redirect_pc     = 64'h0;
      imem_req_ready  = 1'b0;
      imem_resp_valid = 1'b0;
      imem_resp_data  = 32'h0;
      out_ready       = 1'b0;

      test_reset();
      test_sequential();
      test_backpressure();
      test_redirect();
      test_redirect_resp();
      test_wrap();
      test_reset_mid();

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
